// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - raster timing bundle from vga_timing_ctrl to its consumers
//
// Purpose: carries pixel enable, raster position, sync and frame strobe signals.
// Signals:
//   p_tick       pixel enable, one sys_clk cycle wide
//   x, y         horizontal / vertical raster count (SCREEN_WIDTH bits)
//   video_on     (x,y) lies inside the visible area
//   hsync/vsync  active-low sync pulses for the VGA connector
//   frame_start  one-cycle strobe after the frame wrap
//   frame_cnt    frames since reset, wrapping
// Modports: master = timing generator (drives), slave = pixel_gen / game logic (reads).
interface vga_timing_ctrl_if #(
  parameter int SCREEN_WIDTH    = 10,
  parameter int FRAME_CNT_WIDTH = 8
);
  logic                       p_tick;
  logic [SCREEN_WIDTH-1:0]    x;
  logic [SCREEN_WIDTH-1:0]    y;
  logic                       video_on;
  logic                       hsync;
  logic                       vsync;
  logic                       frame_start;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_start, frame_cnt
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing generator with pixel divider and frame strobe
//
// Purpose: divides sys_clk into a pixel-enable tick, runs the horizontal and
// vertical raster counters, and decodes registered video_on/hsync/vsync that
// always line up with the x/y being presented. Emits a per-frame strobe and a
// wrapping frame counter so game logic can update state between frames.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   vga        master modport of vga_timing_ctrl_if (all timing outputs)
module vga_timing_ctrl #(
  parameter int CLK_DIV         = 4,
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SCREEN_WIDTH    = 10,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  vga_timing_ctrl_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW      = SCREEN_WIDTH;
  localparam int FW      = FRAME_CNT_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SW-1:0]    H_LAST   = SW'(H_TOTAL - 1);
  localparam logic [SW-1:0]    V_LAST   = SW'(V_TOTAL - 1);
  localparam logic [SW-1:0]    H_VIS    = SW'(H_DISPLAY);
  localparam logic [SW-1:0]    V_VIS    = SW'(V_DISPLAY);
  // Sync windows are held as inclusive first/last so H_TOTAL itself never
  // has to fit in SCREEN_WIDTH bits.
  localparam logic [SW-1:0]    HS_FIRST = SW'(H_DISPLAY + H_FRONT);
  localparam logic [SW-1:0]    HS_LAST  = SW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [SW-1:0]    VS_FIRST = SW'(V_DISPLAY + V_FRONT);
  localparam logic [SW-1:0]    VS_LAST  = SW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0]    x_q, x_d;
  logic [SW-1:0]    y_q, y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;

  logic tick;
  logic line_end;
  logic frame_end;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign line_end  = (x_q == H_LAST);
  assign frame_end = line_end && (y_q == V_LAST);

  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (tick) begin
      if (line_end) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + SW'(1);
      end else begin
        x_d = x_q + SW'(1);
      end
      // Line and frame wrap on one edge form a single event.
      if (frame_end) begin
        frame_start_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + FW'(1);
      end
    end

    // Decode from the post-update position so the registered flags carry
    // zero latency relative to x/y.
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      if (tick) begin
        x_q        <= x_d;
        y_q        <= y_d;
        video_on_q <= video_on_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
      end
    end
  end

  // With CLK_DIV=1 the decode is permanently true, so reset must mask it.
  assign vga.p_tick      = tick && sys_rst_n;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl on a reduced raster
module tb_vga_timing_ctrl;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int SW = 4, FW = 3;
  localparam int HT = HD + HF + HS + HB;   // 15
  localparam int VT = VD + VF + VS + VB;   // 10
  localparam int FRAME = HT * VT;          // 150 pixel ticks
  localparam int VW = 2 * SW + FW + 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n;
  int   cyc;
  int   pulses;
  int   last_pulse;

  vga_timing_ctrl_if #(.SCREEN_WIDTH(SW), .FRAME_CNT_WIDTH(FW)) vif0 ();
  vga_timing_ctrl_if #(.SCREEN_WIDTH(SW), .FRAME_CNT_WIDTH(FW)) vif1 ();

  vga_timing_ctrl #(
    .CLK_DIV(4), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCREEN_WIDTH(SW), .FRAME_CNT_WIDTH(FW)
  ) u_div4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .vga(vif0)
  );

  vga_timing_ctrl #(
    .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCREEN_WIDTH(SW), .FRAME_CNT_WIDTH(FW)
  ) u_div1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .vga(vif1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Expected outputs from the number of sys_clk edges seen since reset release.
  function automatic logic [VW-1:0] model(input int nn, input int cd, input logic rn);
    int ticks, pos, xx, yy, fr;
    logic pt, vo, hsn, vsn, fs;
    if (!rn) return {1'b0, SW'(0), SW'(0), 1'b0, 1'b1, 1'b1, 1'b0, FW'(0)};
    pt    = (nn % cd) == (cd - 1);
    ticks = nn / cd;
    pos   = ticks % FRAME;
    xx    = pos % HT;
    yy    = pos / HT;
    fr    = (ticks / FRAME) % (1 << FW);
    vo    = (ticks > 0) && (xx < HD) && (yy < VD);
    hsn   = !((xx >= HD + HF) && (xx < HD + HF + HS));
    vsn   = !((yy >= VD + VF) && (yy < VD + VF + VS));
    fs    = (ticks > 0) && ((nn % cd) == 0) && (pos == 0);
    return {pt, SW'(xx), SW'(yy), vo, hsn, vsn, fs, FW'(fr)};
  endfunction

  task automatic step();
    logic [VW-1:0] a0, a1, e0, e1;
    @(negedge clk);
    cyc = cyc + 1;
    if (rst_n) n = n + 1;
    else n = 0;
    a0 = {vif0.p_tick, vif0.x, vif0.y, vif0.video_on, vif0.hsync, vif0.vsync,
          vif0.frame_start, vif0.frame_cnt};
    a1 = {vif1.p_tick, vif1.x, vif1.y, vif1.video_on, vif1.hsync, vif1.vsync,
          vif1.frame_start, vif1.frame_cnt};
    e0 = model(n, 4, rst_n);
    e1 = model(n, 1, rst_n);
    checks = checks + 1;
    if (a0 !== e0) begin
      failures = failures + 1;
      $display("FAIL model_div4 n=%0d got=%h exp=%h", n, a0, e0);
    end
    checks = checks + 1;
    if (a1 !== e1) begin
      failures = failures + 1;
      $display("FAIL model_div1 n=%0d got=%h exp=%h", n, a1, e1);
    end
    if (vif0.frame_start === 1'b1) begin
      pulses = pulses + 1;
      if (last_pulse >= 0) begin
        checks = checks + 1;
        if (cyc - last_pulse != 4 * FRAME) begin
          failures = failures + 1;
          $display("FAIL pulse_spacing got=%0d exp=%0d", cyc - last_pulse, 4 * FRAME);
        end
      end
      last_pulse = cyc;
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 100000) begin
      step();
      guard = guard + 1;
    end
    checks = checks + 1;
    if (n != target) begin
      failures = failures + 1;
      $display("FAIL run_to got=%0d exp=%0d", n, target);
    end
  endtask

  task automatic expect_val(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    checks     = 0;
    failures   = 0;
    n          = 0;
    cyc        = 0;
    pulses     = 0;
    last_pulse = -1;

    repeat (3) step();
    expect_val("rst_x",        int'(vif0.x), 0);
    expect_val("rst_hsync",    int'(vif0.hsync), 1);
    expect_val("rst_vsync",    int'(vif0.vsync), 1);
    expect_val("rst_video_on", int'(vif0.video_on), 0);
    expect_val("rst_ptick_d1", int'(vif1.p_tick), 0);

    rst_n = 1'b1;
    run_to(2);
    expect_val("ptick_cycle3", int'(vif0.p_tick), 0);
    run_to(3);
    expect_val("ptick_cycle4", int'(vif0.p_tick), 1);
    expect_val("d1_ptick",     int'(vif1.p_tick), 1);
    expect_val("d1_x_n3",      int'(vif1.x), 3);
    run_to(4);
    expect_val("x_after_tick",  int'(vif0.x), 1);
    expect_val("video_on_x1",   int'(vif0.video_on), 1);
    run_to(7);
    expect_val("ptick_period",  int'(vif0.p_tick), 1);
    run_to(15);
    expect_val("d1_line_x",     int'(vif1.x), 0);
    expect_val("d1_line_y",     int'(vif1.y), 1);
    run_to(32);
    expect_val("video_off_x8",  int'(vif0.video_on), 0);
    run_to(40);
    expect_val("hsync_lo_x10",  int'(vif0.hsync), 0);
    run_to(48);
    expect_val("hsync_lo_x12",  int'(vif0.hsync), 0);
    run_to(52);
    expect_val("hsync_hi_x13",  int'(vif0.hsync), 1);
    run_to(60);
    expect_val("line_wrap_x",   int'(vif0.x), 0);
    expect_val("line_wrap_y",   int'(vif0.y), 1);
    run_to(360);
    expect_val("video_off_y6",  int'(vif0.video_on), 0);
    run_to(420);
    expect_val("vsync_lo_y7",   int'(vif0.vsync), 0);
    run_to(536);
    expect_val("vsync_lo_y8",   int'(vif0.vsync), 0);
    run_to(540);
    expect_val("vsync_hi_y9",   int'(vif0.vsync), 1);
    run_to(596);
    expect_val("pre_wrap_fs",   int'(vif0.frame_start), 0);
    run_to(600);
    expect_val("wrap_x",        int'(vif0.x), 0);
    expect_val("wrap_y",        int'(vif0.y), 0);
    expect_val("wrap_fs",       int'(vif0.frame_start), 1);
    expect_val("wrap_fcnt",     int'(vif0.frame_cnt), 1);
    run_to(601);
    expect_val("fs_one_cycle",  int'(vif0.frame_start), 0);
    run_to(4 * FRAME * 7);
    expect_val("fcnt_7",        int'(vif0.frame_cnt), 7);
    run_to(4 * FRAME * 8);
    expect_val("fcnt_wrap",     int'(vif0.frame_cnt), 0);
    expect_val("pulse_count",   pulses, 8);

    // Mid-line, mid-divider asynchronous reset: x=5, y=3, div_cnt=2.
    run_to(4 * FRAME * 8 + 4 * (3 * HT + 5) + 2);
    expect_val("pre_rst_x", int'(vif0.x), 5);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_x",       int'(vif0.x), 0);
    expect_val("async_y",       int'(vif0.y), 0);
    expect_val("async_ptick",   int'(vif0.p_tick), 0);
    expect_val("async_d1_tick", int'(vif1.p_tick), 0);
    expect_val("async_hsync",   int'(vif0.hsync), 1);
    expect_val("async_fs",      int'(vif0.frame_start), 0);
    repeat (2) step();
    expect_val("no_rst_pulse",  pulses, 8);

    rst_n = 1'b1;
    run_to(3);
    expect_val("re_ptick_cycle4", int'(vif0.p_tick), 1);
    run_to(4);
    expect_val("re_x_after_tick", int'(vif0.x), 1);
    expect_val("re_video_on",     int'(vif0.video_on), 1);
    run_to(20);
    expect_val("re_pulse_count",  pulses, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
